// File: rtl/n4_b2_mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// n4_b2_mul_seq_pkg
// Shared definitions for the sequential 4x4 shift-and-add multiplier and the
// 4-digit ripple adder it drives.
//   N         : operand width in digits (fixed at 4, matches the adder)
//   STEP_LAST : value of the step counter on the final RUN step (N-1)
//   state_t   : controller state codes IDLE=0, RUN=1, DONE=2
// Optional feature macro used by the multiplier top: N4_MUL_OVF_EN
// ---------------------------------------------------------------------------
package n4_b2_mul_seq_pkg;

  localparam int N = 4;
  localparam logic [2:0] STEP_LAST = 3'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/n4_b2_adder_i.sv
// ---------------------------------------------------------------------------
// n4_b2_adder_i
// 4-digit base-2 ripple-carry adder.
// Ports:
//   x3_x0  in  4  first operand
//   y3_y0  in  4  second operand
//   cin    in  1  carry in
//   s3_s0  out 4  sum digits
//   cout   out 1  carry out of the top digit
//   ow     out 1  two's-complement overflow (carry into MSB xor carry out)
// ---------------------------------------------------------------------------
module n4_b2_adder_i
  import n4_b2_mul_seq_pkg::*;
(
  input  logic [N-1:0] x3_x0,
  input  logic [N-1:0] y3_y0,
  input  logic         cin,
  output logic [N-1:0] s3_s0,
  output logic         cout,
  output logic         ow
);

  logic [N:0] carry;

  // Ripple the carry digit by digit; carry[i] is the carry into digit i.
  always_comb begin
    carry    = '0;
    s3_s0    = '0;
    carry[0] = cin;
    for (int i = 0; i < N; i++) begin
      s3_s0[i]   = x3_x0[i] ^ y3_y0[i] ^ carry[i];
      carry[i+1] = (x3_x0[i] & y3_y0[i]) | (carry[i] & (x3_x0[i] ^ y3_y0[i]));
    end
  end

  assign cout = carry[N];
  assign ow   = carry[N] ^ carry[N-1];

endmodule

// File: rtl/n4_b2_mul_seq.sv
// ---------------------------------------------------------------------------
// n4_b2_mul_seq
// Sequential 4x4 unsigned base-2 multiplier, shift-and-add method. One RUN
// step per cycle for N cycles; each step adds the multiplicand (gated by the
// current multiplier LSB) to the high accumulator through a single
// n4_b2_adder_i, then shifts {cout, sum, Q} right by one.
// Ports:
//   clock   in  1  rising-edge clock
//   reset_  in  1  synchronous active-low reset
//   start   in  1  request, accepted only in IDLE
//   x3_x0   in  4  multiplicand, captured on accepted start
//   y3_y0   in  4  multiplier, captured on accepted start
//   busy    out 1  high while in RUN
//   done    out 1  one-cycle pulse in DONE, product valid
//   p7_p0   out 8  product {A,Q}, held until the next accepted start
//   ow      out 1  only with N4_MUL_OVF_EN: product does not fit in 4 digits
// Optional feature macro: N4_MUL_OVF_EN
// ---------------------------------------------------------------------------
module n4_b2_mul_seq
  import n4_b2_mul_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset_,
  input  logic         start,
  input  logic [N-1:0] x3_x0,
  input  logic [N-1:0] y3_y0,
  output logic         busy,
  output logic         done,
  output logic [7:0]   p7_p0
`ifdef N4_MUL_OVF_EN
  ,
  output logic         ow
`endif
);

  state_t       state;
  logic [N-1:0] mcand;
  logic [N-1:0] acc;
  logic [N-1:0] mplier;
  logic [2:0]   cnt;

  logic [N-1:0] add_y;
  logic [N-1:0] sum;
  logic         sum_cout;
  logic         adder_ow_unused;

  // Partial product: the multiplicand when the current multiplier bit is set.
  assign add_y = mplier[0] ? mcand : '0;

  n4_b2_adder_i u_adder (
    .x3_x0 (acc),
    .y3_y0 (add_y),
    .cin   (1'b0),
    .s3_s0 (sum),
    .cout  (sum_cout),
    .ow    (adder_ow_unused)
  );

  // The adder carry shifts straight into the accumulator MSB, so it is never
  // lost and needs no separate holding register.
  always_ff @(posedge clock) begin
    if (!reset_) begin
      state  <= IDLE;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= x3_x0;
            mplier <= y3_y0;
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= {sum_cout, sum[N-1:1]};
          mplier <= {sum[0], mplier[N-1:1]};
          cnt    <= cnt + 3'd1;
          if (cnt == STEP_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign p7_p0 = {acc, mplier};

`ifdef N4_MUL_OVF_EN
  assign ow = |acc;
`endif

endmodule

// File: tb/tb_n4_b2_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_n4_b2_mul_seq
// Self-checking bench for n4_b2_mul_seq. Expected products come from plain
// integer multiplication of the operands captured at the accepted start.
// Optional feature macro: N4_MUL_OVF_EN (ow checked only when defined)
// ---------------------------------------------------------------------------
module tb_n4_b2_mul_seq;

  logic       clock;
  logic       reset_;
  logic       start;
  logic [3:0] x3_x0;
  logic [3:0] y3_y0;
  logic       busy;
  logic       done;
  logic [7:0] p7_p0;
`ifdef N4_MUL_OVF_EN
  logic       ow;
`endif

  int checkCount = 0;
  int errorCount = 0;

  n4_b2_mul_seq dut (
    .clock  (clock),
    .reset_ (reset_),
    .start  (start),
    .x3_x0  (x3_x0),
    .y3_y0  (y3_y0),
    .busy   (busy),
    .done   (done),
    .p7_p0  (p7_p0)
`ifdef N4_MUL_OVF_EN
    ,
    .ow     (ow)
`endif
  );

  // Free-running clock; DUT outputs are sampled on the falling edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Product and overflow flag checks against the arithmetic reference.
  task automatic checkResult(input string tag, input int prod);
    checkOutput({tag, "_p"}, 16'(p7_p0), 16'(prod));
`ifdef N4_MUL_OVF_EN
    checkOutput({tag, "_ow"}, 16'(ow), 16'((prod >> 4) != 0));
`endif
  endtask

  // One full multiplication with strict latency checks. With disturb set,
  // start and the operand inputs are scrambled during RUN.
  task automatic applyStimulus(input logic [3:0] x, input logic [3:0] y,
                               input bit disturb);
    int prod;
    prod = int'(x) * int'(y);
    @(negedge clock);
    x3_x0 = x;
    y3_y0 = y;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      start = 1'b0;
      if (disturb) begin
        start = 1'($urandom_range(0, 1));
        x3_x0 = 4'($urandom_range(0, 15));
        y3_y0 = 4'($urandom_range(0, 15));
      end
      checkOutput("run_busy", 16'(busy), 16'd1);
      checkOutput("run_done", 16'(done), 16'd0);
    end
    @(negedge clock);
    start = 1'b0;
    checkOutput("done_pulse", 16'(done), 16'd1);
    checkOutput("done_busy", 16'(busy), 16'd0);
    checkResult("done", prod);
    @(negedge clock);
    checkOutput("idle_done", 16'(done), 16'd0);
    checkOutput("idle_busy", 16'(busy), 16'd0);
    checkResult("hold", prod);
  endtask

  // start held high across DONE: one idle cycle, then a restart that
  // captures the operands present at that edge.
  task automatic runHeld(input logic [3:0] x1, input logic [3:0] y1,
                         input logic [3:0] x2, input logic [3:0] y2);
    @(negedge clock);
    x3_x0 = x1;
    y3_y0 = y1;
    start = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checkOutput("held_busy1", 16'(busy), 16'd1);
    end
    @(negedge clock);
    checkOutput("held_done1", 16'(done), 16'd1);
    checkResult("held1", int'(x1) * int'(y1));
    x3_x0 = x2;
    y3_y0 = y2;
    @(negedge clock);
    checkOutput("held_idle_busy", 16'(busy), 16'd0);
    checkOutput("held_idle_done", 16'(done), 16'd0);
    repeat (4) begin
      @(negedge clock);
      checkOutput("held_busy2", 16'(busy), 16'd1);
      checkOutput("held_nodone", 16'(done), 16'd0);
    end
    @(negedge clock);
    start = 1'b0;
    checkOutput("held_done2", 16'(done), 16'd1);
    checkResult("held2", int'(x2) * int'(y2));
    @(negedge clock);
    checkOutput("held_after", 16'(done), 16'd0);
  endtask

  // Reset asserted during the second RUN cycle must clear everything.
  task automatic runMidReset;
    @(negedge clock);
    x3_x0 = 4'd11;
    y3_y0 = 4'd13;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("mr_busy", 16'(busy), 16'd1);
    @(negedge clock);
    reset_ = 1'b0;
    @(negedge clock);
    checkOutput("mr_busy0", 16'(busy), 16'd0);
    checkOutput("mr_done0", 16'(done), 16'd0);
    checkResult("mr", 0);
    reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b0;
    start  = 1'b0;
    x3_x0  = '0;
    y3_y0  = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_done", 16'(done), 16'd0);
    checkResult("rst", 0);
    reset_ = 1'b1;

    applyStimulus(4'd3, 4'd5, 1'b0);
    applyStimulus(4'hF, 4'hF, 1'b0);
    applyStimulus(4'd9, 4'd0, 1'b0);
    applyStimulus(4'd0, 4'd7, 1'b0);
    applyStimulus(4'd6, 4'd7, 1'b1);
    runMidReset();
    applyStimulus(4'd12, 4'd10, 1'b0);
    runHeld(4'd5, 4'd9, 4'd13, 4'd11);

    for (int n = 0; n < 24; n++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
